// File: rtl/exposure_seq_multitap.sv
// exposure_seq_multitap
//   Coded-exposure sequencer for the pixel array. A frame is one global reset
//   followed by NUM_PAT sub-frames. Each sub-frame is an exposure followed by
//   NUM_REP rounds of (global-subtract pulse + row-mask load). Sub-frames steer
//   charge to the taps in round-robin order. When the frame is finished, the
//   block raises a readout request and waits for the readout FSM.
//
// Ports
//   CLKM, rst            clock, synchronous active-high reset
//   enable, re_busy      frame start permission / readout handshake
//   trigger_o            readout request, held until re_busy is seen high
//   exp_busy             exposure activity (EXP through TRIGGER)
//   TAP_SEL, PIXGSUBC    one-hot tap select, per-tap global-subtract gate
//   PIXDRAIN, PIXGLOB_RES, PIXVTG_GLOB, EN_STREAM, DES_2ND, MASK_EN
//                        pixel and mask-chain controls
//   ROWADD               mask-load row address
//   NUM_PAT .. T_MU_wait configuration, captured when a frame starts
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | drain on, waiting for enable with readout idle
// RESET   | global pixel reset, Treset+1 cycles
// EXP     | exposure into the active tap, Texp+1 cycles
// GSUB    | global-subtract pulse on the active tap
// MASK    | row-mask load, MASK_DES cycles per row
// DONE    | one cycle between rounds; advances repeat/pattern/tap
// TRIGGER | request readout, wait for re_busy
module exposure_seq_multitap #(
  parameter int NUM_TAPS = 2,
  parameter int ROW_W    = 9,
  parameter int MASK_DES = 16,
  parameter int CNT_W    = 32
) (
  input  logic                CLKM,
  input  logic                rst,
  input  logic                enable,
  input  logic                re_busy,
  input  logic [CNT_W-1:0]    NUM_PAT,
  input  logic [CNT_W-1:0]    NUM_REP,
  input  logic [CNT_W-1:0]    NUM_ROW,
  input  logic [CNT_W-1:0]    Treset,
  input  logic [CNT_W-1:0]    Texp,
  input  logic [CNT_W-1:0]    Tgsub_w,
  input  logic [CNT_W-1:0]    Tadd,
  input  logic [CNT_W-1:0]    Tdes2_d,
  input  logic [CNT_W-1:0]    Tdes2_w,
  input  logic [CNT_W-1:0]    Tmsken_d,
  input  logic [CNT_W-1:0]    Tmsken_w,
  input  logic [CNT_W-1:0]    T_MU_wait,
  output logic                trigger_o,
  output logic                exp_busy,
  output logic [NUM_TAPS-1:0] TAP_SEL,
  output logic [NUM_TAPS-1:0] PIXGSUBC,
  output logic                PIXDRAIN,
  output logic                PIXGLOB_RES,
  output logic                PIXVTG_GLOB,
  output logic                EN_STREAM,
  output logic                DES_2ND,
  output logic                MASK_EN,
  output logic [ROW_W-1:0]    ROWADD
);

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [TAP_W-1:0]    TAP_LAST = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W-1:0]    TAP_INC  = TAP_W'(1);
  localparam logic [NUM_TAPS-1:0] TAP_ONE  = NUM_TAPS'(1);
  localparam logic [CNT_W-1:0]    ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]    DES_C    = CNT_W'(MASK_DES);
  localparam logic [CNT_W:0]      DES_X    = (CNT_W+1)'(MASK_DES);
  localparam logic [CNT_W:0]      ROW_MAX  = (CNT_W+1)'(1) << ROW_W;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_EXP, S_GSUB, S_MASK, S_DONE, S_TRIGGER
  } state_t;

  state_t st, st_nxt;

  logic [CNT_W-1:0] num_pat_s, num_rep_s, num_row_s, texp_s, tgsub_w_s, tadd_s;
  logic [CNT_W-1:0] tdes2_d_s, tdes2_w_s, tmsken_d_s, tmsken_w_s, t_mu_wait_s;
  logic             ld_cfg;

  logic [CNT_W-1:0] tmr, tmr_nxt;
  logic [CNT_W-1:0] slot, slot_nxt;
  logic [CNT_W-1:0] row, row_nxt;
  logic [CNT_W-1:0] rep_cnt, rep_nxt;
  logic [CNT_W-1:0] pat_cnt, pat_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic [TAP_W-1:0] tap_idx, tap_nxt;

  logic                trig_nxt, busy_nxt, drain_nxt, gres_nxt, vtg_nxt;
  logic                ens_nxt, des2_nxt, msk_nxt;
  logic [NUM_TAPS-1:0] tsel_nxt, gsubc_nxt;
  logic [ROW_W-1:0]    rowadd_nxt;

  logic [NUM_TAPS-1:0] tap_oh;
  logic [CNT_W-1:0]    gsub_last;
  logic [CNT_W:0]      rows_lim;
  logic                last_row;

  always_comb begin
    tap_oh    = TAP_ONE << tap_idx;
    // Tgsub_w of 0 is treated as a one-cycle pulse
    gsub_last = (tgsub_w_s == '0) ? '0 : tgsub_w_s - ONE;
    // rows beyond the addressable range are dropped
    rows_lim  = ({1'b0, num_row_s} > ROW_MAX) ? ROW_MAX : {1'b0, num_row_s};
    last_row  = (({1'b0, row} + (CNT_W+1)'(1)) == rows_lim);
  end

  always_comb begin
    st_nxt     = st;
    tmr_nxt    = tmr;
    slot_nxt   = slot;
    row_nxt    = row;
    rep_nxt    = rep_cnt;
    pat_nxt    = pat_cnt;
    wait_nxt   = wait_cnt;
    tap_nxt    = tap_idx;
    ld_cfg     = 1'b0;
    trig_nxt   = 1'b0;
    busy_nxt   = 1'b0;
    drain_nxt  = 1'b0;
    gres_nxt   = 1'b0;
    vtg_nxt    = 1'b0;
    ens_nxt    = 1'b0;
    des2_nxt   = 1'b0;
    msk_nxt    = 1'b0;
    tsel_nxt   = '0;
    gsubc_nxt  = '0;
    rowadd_nxt = ROWADD;

    case (st)
      S_IDLE: begin
        drain_nxt = 1'b1;
        if (enable && !re_busy) begin
          st_nxt  = S_RESET;
          tmr_nxt = Treset;
          ld_cfg  = 1'b1;
        end
      end

      S_RESET: begin
        drain_nxt = 1'b1;
        gres_nxt  = 1'b1;
        vtg_nxt   = 1'b1;
        if (tmr == '0) begin
          pat_nxt = num_pat_s;
          tap_nxt = '0;
          if (num_pat_s == '0) begin
            st_nxt   = S_TRIGGER;
            wait_nxt = ONE;
          end else begin
            st_nxt  = S_EXP;
            tmr_nxt = texp_s;
          end
        end else begin
          tmr_nxt = tmr - ONE;
        end
      end

      S_EXP: begin
        busy_nxt = 1'b1;
        tsel_nxt = tap_oh;
        if (tmr == '0) begin
          rep_nxt = (num_rep_s == '0) ? ONE : num_rep_s;
          st_nxt  = S_GSUB;
          tmr_nxt = gsub_last;
        end else begin
          tmr_nxt = tmr - ONE;
        end
      end

      S_GSUB: begin
        busy_nxt  = 1'b1;
        tsel_nxt  = tap_oh;
        gsubc_nxt = tap_oh;
        if (tmr == '0) begin
          if (num_row_s == '0) begin
            st_nxt = S_DONE;
          end else begin
            st_nxt   = S_MASK;
            row_nxt  = '0;
            slot_nxt = ONE;
          end
        end else begin
          tmr_nxt = tmr - ONE;
        end
      end

      S_MASK: begin
        busy_nxt = 1'b1;
        tsel_nxt = tap_oh;
        if (slot == tadd_s) rowadd_nxt = row[ROW_W-1:0];
        // window ends computed one bit wider so large delay+width cannot wrap
        des2_nxt = (slot >= tdes2_d_s) &&
                   ({1'b0, slot} < ({1'b0, tdes2_d_s} + {1'b0, tdes2_w_s}));
        msk_nxt  = (slot >= tmsken_d_s) &&
                   ({1'b0, slot} < ({1'b0, tmsken_d_s} + {1'b0, tmsken_w_s}));
        ens_nxt  = !last_row || (({1'b0, slot} + {1'b0, tdes2_d_s}) <= DES_X);
        if (slot == DES_C) begin
          if (last_row) begin
            st_nxt = S_DONE;
          end else begin
            row_nxt  = row + ONE;
            slot_nxt = ONE;
          end
        end else begin
          slot_nxt = slot + ONE;
        end
      end

      S_DONE: begin
        busy_nxt   = 1'b1;
        tsel_nxt   = tap_oh;
        rowadd_nxt = '0;
        if (rep_cnt > ONE) begin
          rep_nxt = rep_cnt - ONE;
          st_nxt  = S_GSUB;
          tmr_nxt = gsub_last;
        end else begin
          rep_nxt = '0;
          tap_nxt = (tap_idx == TAP_LAST) ? '0 : tap_idx + TAP_INC;
          if (pat_cnt > ONE) begin
            pat_nxt = pat_cnt - ONE;
            st_nxt  = S_EXP;
            tmr_nxt = texp_s;
          end else begin
            pat_nxt  = '0;
            st_nxt   = S_TRIGGER;
            wait_nxt = ONE;
          end
        end
      end

      S_TRIGGER: begin
        drain_nxt = 1'b1;
        busy_nxt  = 1'b1;
        // re_busy both ends the request and suppresses it in the same cycle
        trig_nxt  = (wait_cnt >= t_mu_wait_s) && !re_busy;
        if (re_busy) begin
          st_nxt = S_IDLE;
        end else if (wait_cnt < t_mu_wait_s) begin
          wait_nxt = wait_cnt + ONE;
        end
      end

      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKM) begin
    if (rst) begin
      st          <= S_IDLE;
      tmr         <= '0;
      slot        <= '0;
      row         <= '0;
      rep_cnt     <= '0;
      pat_cnt     <= '0;
      wait_cnt    <= '0;
      tap_idx     <= '0;
      num_pat_s   <= '0;
      num_rep_s   <= '0;
      num_row_s   <= '0;
      texp_s      <= '0;
      tgsub_w_s   <= '0;
      tadd_s      <= '0;
      tdes2_d_s   <= '0;
      tdes2_w_s   <= '0;
      tmsken_d_s  <= '0;
      tmsken_w_s  <= '0;
      t_mu_wait_s <= '0;
      trigger_o   <= 1'b0;
      exp_busy    <= 1'b0;
      TAP_SEL     <= '0;
      PIXGSUBC    <= '0;
      PIXDRAIN    <= 1'b1;
      PIXGLOB_RES <= 1'b0;
      PIXVTG_GLOB <= 1'b0;
      EN_STREAM   <= 1'b0;
      DES_2ND     <= 1'b0;
      MASK_EN     <= 1'b0;
      ROWADD      <= '0;
    end else begin
      st       <= st_nxt;
      tmr      <= tmr_nxt;
      slot     <= slot_nxt;
      row      <= row_nxt;
      rep_cnt  <= rep_nxt;
      pat_cnt  <= pat_nxt;
      wait_cnt <= wait_nxt;
      tap_idx  <= tap_nxt;
      if (ld_cfg) begin
        num_pat_s   <= NUM_PAT;
        num_rep_s   <= NUM_REP;
        num_row_s   <= NUM_ROW;
        texp_s      <= Texp;
        tgsub_w_s   <= Tgsub_w;
        tadd_s      <= Tadd;
        tdes2_d_s   <= Tdes2_d;
        tdes2_w_s   <= Tdes2_w;
        tmsken_d_s  <= Tmsken_d;
        tmsken_w_s  <= Tmsken_w;
        t_mu_wait_s <= T_MU_wait;
      end
      trigger_o   <= trig_nxt;
      exp_busy    <= busy_nxt;
      TAP_SEL     <= tsel_nxt;
      PIXGSUBC    <= gsubc_nxt;
      PIXDRAIN    <= drain_nxt;
      PIXGLOB_RES <= gres_nxt;
      PIXVTG_GLOB <= vtg_nxt;
      EN_STREAM   <= ens_nxt;
      DES_2ND     <= des2_nxt;
      MASK_EN     <= msk_nxt;
      ROWADD      <= rowadd_nxt;
    end
  end

endmodule

// File: tb/tb_exposure_seq_multitap.sv
// tb_exposure_seq_multitap
//   Drives whole frames through exposure_seq_multitap (3 taps, 8 addressable
//   rows) and compares every output cycle against a per-frame expected
//   waveform built from the sequencing rules.
module tb_exposure_seq_multitap;
  localparam int NT  = 3;
  localparam int RW  = 3;
  localparam int DES = 16;

  logic CLKM = 1'b0;
  logic rst, enable, re_busy;
  logic [31:0] NUM_PAT, NUM_REP, NUM_ROW, Treset, Texp, Tgsub_w, Tadd;
  logic [31:0] Tdes2_d, Tdes2_w, Tmsken_d, Tmsken_w, T_MU_wait;
  logic trigger_o, exp_busy, PIXDRAIN, PIXGLOB_RES, PIXVTG_GLOB;
  logic EN_STREAM, DES_2ND, MASK_EN;
  logic [NT-1:0] TAP_SEL, PIXGSUBC;
  logic [RW-1:0] ROWADD;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  int first_mask;

  exposure_seq_multitap #(.NUM_TAPS(NT), .ROW_W(RW), .MASK_DES(DES), .CNT_W(32)) dut (
    .CLKM(CLKM), .rst(rst), .enable(enable), .re_busy(re_busy),
    .NUM_PAT(NUM_PAT), .NUM_REP(NUM_REP), .NUM_ROW(NUM_ROW), .Treset(Treset),
    .Texp(Texp), .Tgsub_w(Tgsub_w), .Tadd(Tadd), .Tdes2_d(Tdes2_d),
    .Tdes2_w(Tdes2_w), .Tmsken_d(Tmsken_d), .Tmsken_w(Tmsken_w),
    .T_MU_wait(T_MU_wait), .trigger_o(trigger_o), .exp_busy(exp_busy),
    .TAP_SEL(TAP_SEL), .PIXGSUBC(PIXGSUBC), .PIXDRAIN(PIXDRAIN),
    .PIXGLOB_RES(PIXGLOB_RES), .PIXVTG_GLOB(PIXVTG_GLOB), .EN_STREAM(EN_STREAM),
    .DES_2ND(DES_2ND), .MASK_EN(MASK_EN), .ROWADD(ROWADD)
  );

  always #5 CLKM = ~CLKM;

  function automatic logic [31:0] pk(input logic trig, busy,
                                     input logic [2:0] tsel, gs,
                                     input logic drain, gres, vtg, ens, des2, msk,
                                     input logic [2:0] ra);
    return {15'd0, trig, busy, tsel, gs, drain, gres, vtg, ens, des2, msk, ra};
  endfunction

  function automatic logic [31:0] obs();
    return pk(trigger_o, exp_busy, TAP_SEL, PIXGSUBC, PIXDRAIN, PIXGLOB_RES,
              PIXVTG_GLOB, EN_STREAM, DES_2ND, MASK_EN, ROWADD);
  endfunction

  function automatic logic [31:0] idle_vec();
    return pk(1'b0, 1'b0, 3'b0, 3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, expv);
    end
  endtask

  task automatic set_cfg(input longint pat, rep, row, trs, tex, tgs, tad,
                         input longint d2d, d2w, mkd, mkw, tmu);
    NUM_PAT = 32'(pat); NUM_REP = 32'(rep); NUM_ROW = 32'(row);
    Treset = 32'(trs); Texp = 32'(tex); Tgsub_w = 32'(tgs); Tadd = 32'(tad);
    Tdes2_d = 32'(d2d); Tdes2_w = 32'(d2w); Tmsken_d = 32'(mkd);
    Tmsken_w = 32'(mkw); T_MU_wait = 32'(tmu);
  endtask

  task automatic scramble_cfg();
    NUM_PAT = $urandom(); NUM_REP = $urandom(); NUM_ROW = $urandom();
    Treset = $urandom(); Texp = $urandom(); Tgsub_w = $urandom();
    Tadd = $urandom(); Tdes2_d = $urandom(); Tdes2_w = $urandom();
    Tmsken_d = $urandom(); Tmsken_w = $urandom(); T_MU_wait = $urandom();
  endtask

  // Expected output waveform from RESET through the last DONE, one entry per cycle.
  task automatic build_trace();
    longint d2d, d2w, mkd, mkw, tad, nrows, reps, gw;
    logic [2:0] ra, tsel;
    d2d = Tdes2_d; d2w = Tdes2_w; mkd = Tmsken_d; mkw = Tmsken_w; tad = Tadd;
    nrows = (NUM_ROW > 32'd8) ? 8 : NUM_ROW;
    reps  = (NUM_REP == 0) ? 1 : NUM_REP;
    gw    = (Tgsub_w == 0) ? 1 : Tgsub_w;
    exp_q.delete();
    first_mask = -1;
    ra = 3'b0;
    for (longint k = 0; k <= longint'(Treset); k++)
      exp_q.push_back(pk(0, 0, 3'b0, 3'b0, 1, 1, 1, 0, 0, 0, 3'b0));
    for (int p = 0; p < int'(NUM_PAT); p++) begin
      tsel = 3'b001 << (p % NT);
      for (longint k = 0; k <= longint'(Texp); k++)
        exp_q.push_back(pk(0, 1, tsel, 3'b0, 0, 0, 0, 0, 0, 0, ra));
      for (longint rp = 0; rp < reps; rp++) begin
        for (longint k = 0; k < gw; k++)
          exp_q.push_back(pk(0, 1, tsel, tsel, 0, 0, 0, 0, 0, 0, ra));
        for (longint r = 0; r < nrows; r++) begin
          for (longint c = 1; c <= DES; c++) begin
            logic des2, msk, ens;
            if (c == tad) ra = 3'(r);
            des2 = (c >= d2d) && (c < d2d + d2w);
            msk  = (c >= mkd) && (c < mkd + mkw);
            ens  = (r < nrows - 1) || (c + d2d <= DES);
            if (first_mask < 0) first_mask = exp_q.size();
            exp_q.push_back(pk(0, 1, tsel, 3'b0, 0, 0, 0, ens, des2, msk, ra));
          end
        end
        ra = 3'b0;
        exp_q.push_back(pk(0, 1, tsel, 3'b0, 0, 0, 0, 0, 0, 0, 3'b0));
      end
    end
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_frame(input string name, input int hold, input int abort_off,
                           input bit scramble);
    int abort_at, hold_trig, len;
    longint tmu, j;
    bit rb, fin;
    build_trace();
    len = exp_q.size();
    tmu = T_MU_wait;
    abort_at = (abort_off >= 0 && first_mask >= 0) ? first_mask + abort_off : -1;
    enable  = 1'b1;
    re_busy = (hold > 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge CLKM); #1;
      check($sformatf("%s idle_hold%0d", name, k), obs(), idle_vec());
    end
    re_busy = 1'b0;
    @(posedge CLKM); #1;
    enable = 1'b0;
    check($sformatf("%s start", name), obs(), idle_vec());
    for (int i = 0; i < len; i++) begin
      @(posedge CLKM); #1;
      check($sformatf("%s cyc%0d", name, i), obs(), exp_q[i]);
      if (i == abort_at) begin
        re_busy = 1'b0;
        rst = 1'b1;
        @(posedge CLKM); #1;
        check($sformatf("%s abort_rst", name), obs(), idle_vec());
        rst = 1'b0;
        @(posedge CLKM); #1;
        check($sformatf("%s abort_idle", name), obs(), idle_vec());
        return;
      end
      re_busy = (i < len - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (scramble && $urandom_range(0, 7) == 0) scramble_cfg();
    end
    hold_trig = $urandom_range(0, int'(tmu) + 3);
    j = 1;
    fin = 1'b0;
    while (!fin) begin
      rb = (j > hold_trig);
      re_busy = rb;
      @(posedge CLKM); #1;
      check($sformatf("%s trig%0d", name, j), obs(),
            pk((j >= tmu) && !rb, 1, 3'b0, 3'b0, 1, 0, 0, 0, 0, 0, 3'b0));
      fin = rb;
      j++;
    end
    re_busy = 1'b0;
    @(posedge CLKM); #1;
    check($sformatf("%s end_idle", name), obs(), idle_vec());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; re_busy = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge CLKM);
    #1;
    check("reset_values", obs(), idle_vec());
    rst = 1'b0;
    @(posedge CLKM); #1;
    check("idle_after_reset", obs(), idle_vec());

    set_cfg(2, 1, 3, 4, 10, 3, 2, 5, 3, 9, 2, 3);
    run_frame("basic", 0, -1, 1'b0);
    set_cfg(1, 1, 4, 1, 2, 1, 2, 5, 3, 9, 2, 2);
    run_frame("mask_timing", 0, -1, 1'b1);
    set_cfg(4, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 1);
    run_frame("tap_wrap", 0, -1, 1'b0);
    set_cfg(0, 2, 3, 2, 3, 1, 1, 1, 1, 1, 1, 0);
    run_frame("no_pat", 0, -1, 1'b0);
    set_cfg(2, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 2);
    run_frame("rep0_row0", 0, -1, 1'b0);
    set_cfg(1, 2, 2, 0, 1, 2, 3, 4, 4, 6, 2, 4);
    run_frame("idle_hold", 4, -1, 1'b0);
    set_cfg(1, 1, 10, 0, 0, 1, 1, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 0, 64'hFFFF_FFFF, 1);
    run_frame("row_clamp_wide", 0, -1, 1'b0);
    set_cfg(1, 1, 3, 1, 2, 1, 2, 5, 3, 9, 2, 2);
    run_frame("abort_mask", 0, 21, 1'b0);
    set_cfg(1, 1, 2, 0, 1, 1, 2, 5, 3, 9, 2, 1);
    run_frame("post_abort", 0, -1, 1'b0);

    for (int f = 0; f < 20; f++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 9),
              $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3),
              $urandom_range(0, 17), $urandom_range(0, 18), $urandom_range(0, 6),
              $urandom_range(0, 18), $urandom_range(0, 6), $urandom_range(0, 5));
      run_frame($sformatf("rand%0d", f), $urandom_range(0, 2), -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
